// File: rtl/clock_switch_ctrl.sv
// clock_switch_ctrl: sequencer for every CPU clock-source change.
// Synchronizes and debounces the speed switch and JP2-JP4 jumpers. Waits for
// an idle 68000 bus cycle, then gates CLKCPU, reprograms the selector one-hots
// and bank, waits for settling and ungates. Falls back to C7M when the PLL
// loses lock while a PLL-derived clock is applied.
// Ports:
//   C7M, RESET                  sole clock / synchronous active-high reset
//   CPU_SPEED_SWITCH            1 = stock C7M, 0 = turbo code {JP2,JP3,JP4}
//   JP2, JP3, JP4               turbo code jumpers (asynchronous)
//   AS_CPU_n, DTACK_CPU_n       bus idle when both high (already C7M domain)
//   PLL_LOCK                    PLL lock (asynchronous)
//   CLKSEL0, CLKSEL1            selector one-hots (C7M..C28M / C33M..OSC)
//   BANK_SEL, USE_C7M           selector bank / C7M bypass
//   CLK_EN                      CPU clock gate enable
//   BUSY, LOCK_FAULT, APPLIED   sequencing, sticky lock fault, applied code
module clock_switch_ctrl #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned GATE_CYCLES     = 2,
    parameter int unsigned SETTLE_CYCLES   = 8
) (
    input  logic       C7M,
    input  logic       RESET,
    input  logic       CPU_SPEED_SWITCH,
    input  logic       JP2,
    input  logic       JP3,
    input  logic       JP4,
    input  logic       AS_CPU_n,
    input  logic       DTACK_CPU_n,
    input  logic       PLL_LOCK,
    output logic [3:0] CLKSEL0,
    output logic [3:0] CLKSEL1,
    output logic       BANK_SEL,
    output logic       USE_C7M,
    output logic       CLK_EN,
    output logic       BUSY,
    output logic       LOCK_FAULT,
    output logic [3:0] APPLIED
);

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TM_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TM_W   = (TM_MAX > 1) ? $clog2(TM_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] GATE_LAST   = TM_W'(GATE_CYCLES - 1);
    localparam logic [TM_W-1:0] SETTLE_LAST = TM_W'(SETTLE_CYCLES - 1);

    localparam logic [3:0] C7M_CODE = 4'b1000;
    // Synchronizer reset image {sw, jp2, jp3, jp4, lock}: requests stock C7M.
    localparam logic [4:0] SYNC_RST = 5'b10000;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_BUS = 3'd1;
    localparam logic [2:0] S_GATE_OFF = 3'd2;
    localparam logic [2:0] S_SELECT   = 3'd3;
    localparam logic [2:0] S_SETTLE   = 3'd4;
    localparam logic [2:0] S_GATE_ON  = 3'd5;

    function automatic logic needs_pll(input logic [3:0] t);
        return (t[3] == 1'b0) && (t[2:0] != 3'b000) && (t[2:0] != 3'b111);
    endfunction

    // Input synchronizer chain
    logic [4:0] sync_q [SYNC_STAGES];

    always_ff @(posedge C7M) begin
        if (RESET) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            sync_q[0] <= {CPU_SPEED_SWITCH, JP2, JP3, JP4, PLL_LOCK};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    logic [4:0] sync_out;
    logic       sw_s;
    logic [2:0] jp_s;
    logic       lock_s;
    logic [3:0] req;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign sw_s     = sync_out[4];
    assign jp_s     = sync_out[3:1];
    assign lock_s   = sync_out[0];
    // Switch at stock ignores the jumper code entirely.
    assign req      = sw_s ? C7M_CODE : {1'b0, jp_s};

    // Debounce: cand holds last cycle's request, db_cnt counts repeats of it.
    logic [3:0]      cand;
    logic [3:0]      stable;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nx;

    always_comb begin
        db_cnt_nx = db_cnt;
        if (req != cand) begin
            db_cnt_nx = '0;
        end else if (db_cnt != DB_LAST) begin
            db_cnt_nx = db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge C7M) begin
        if (RESET) begin
            cand   <= C7M_CODE;
            db_cnt <= '0;
            stable <= C7M_CODE;
        end else begin
            cand   <= req;
            db_cnt <= db_cnt_nx;
            // Latch on the edge where the count reaches its last value.
            if (db_cnt_nx == DB_LAST) stable <= req;
        end
    end

    // Sequencer
    logic [2:0]      state, state_nx;
    logic [TM_W-1:0] timer, timer_nx;
    logic [3:0]      target, target_nx;
    logic [3:0]      clksel0_nx, clksel1_nx, applied_nx;
    logic            bank_nx, use_nx, clk_en_nx, busy_nx, fault_nx;
    logic            bus_idle, fallback;
    logic [3:0]      pending;

    assign bus_idle = AS_CPU_n && DTACK_CPU_n;
    assign fallback = !lock_s && needs_pll(APPLIED);
    assign pending  = fallback ? C7M_CODE : stable;

    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        target_nx  = target;
        clksel0_nx = CLKSEL0;
        clksel1_nx = CLKSEL1;
        bank_nx    = BANK_SEL;
        use_nx     = USE_C7M;
        applied_nx = APPLIED;
        fault_nx   = LOCK_FAULT;

        case (state)
            S_IDLE: begin
                if ((stable != APPLIED) || fallback) state_nx = S_WAIT_BUS;
            end
            S_WAIT_BUS: begin
                if (pending == APPLIED) begin
                    state_nx = S_IDLE;
                end else if (fallback) begin
                    // Lock loss does not wait for an idle bus.
                    state_nx  = S_GATE_OFF;
                    target_nx = C7M_CODE;
                    fault_nx  = 1'b1;
                    timer_nx  = '0;
                end else if (bus_idle && (lock_s || !needs_pll(pending))) begin
                    state_nx  = S_GATE_OFF;
                    target_nx = pending;
                    timer_nx  = '0;
                end
            end
            S_GATE_OFF: begin
                if (timer == GATE_LAST) begin
                    state_nx = S_SELECT;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + TM_W'(1);
                end
            end
            S_SELECT: begin
                use_nx     = target[3];
                bank_nx    = target[2];
                // Only the selected bank is rewritten; the other keeps its value.
                if (target[2]) clksel1_nx = 4'b0001 << target[1:0];
                else           clksel0_nx = 4'b0001 << target[1:0];
                applied_nx = target;
                state_nx   = S_SETTLE;
                timer_nx   = '0;
            end
            S_SETTLE: begin
                if (timer == SETTLE_LAST) state_nx = S_GATE_ON;
                else                      timer_nx = timer + TM_W'(1);
            end
            S_GATE_ON: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        clk_en_nx = !(state_nx inside {S_GATE_OFF, S_SELECT, S_SETTLE});
        busy_nx   = (state_nx != S_IDLE);
    end

    always_ff @(posedge C7M) begin
        if (RESET) begin
            state      <= S_IDLE;
            timer      <= '0;
            target     <= C7M_CODE;
            CLKSEL0    <= 4'b0001;
            CLKSEL1    <= 4'b0001;
            BANK_SEL   <= 1'b0;
            USE_C7M    <= 1'b1;
            CLK_EN     <= 1'b1;
            BUSY       <= 1'b0;
            LOCK_FAULT <= 1'b0;
            APPLIED    <= C7M_CODE;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            target     <= target_nx;
            CLKSEL0    <= clksel0_nx;
            CLKSEL1    <= clksel1_nx;
            BANK_SEL   <= bank_nx;
            USE_C7M    <= use_nx;
            CLK_EN     <= clk_en_nx;
            BUSY       <= busy_nx;
            LOCK_FAULT <= fault_nx;
            APPLIED    <= applied_nx;
        end
    end

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Self-checking bench for clock_switch_ctrl: directed scenarios with literal
// expectations plus randomized stimulus checked every cycle against a
// behavioural model (delay line, run-length debounce, sequence timeline).
module tb_clock_switch_ctrl;

    localparam int S   = 2;
    localparam int DEB = 16;
    localparam int G   = 2;
    localparam int ST  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw = 1'b1;
    logic [2:0] jp = 3'b000;
    logic as_n = 1'b1, dt_n = 1'b1, lock = 1'b1;

    logic [3:0] CLKSEL0, CLKSEL1, APPLIED;
    logic BANK_SEL, USE_C7M, CLK_EN, BUSY, LOCK_FAULT;

    clock_switch_ctrl #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB), .GATE_CYCLES(G), .SETTLE_CYCLES(ST)
    ) dut (
        .C7M(clk), .RESET(rst), .CPU_SPEED_SWITCH(sw),
        .JP2(jp[2]), .JP3(jp[1]), .JP4(jp[0]),
        .AS_CPU_n(as_n), .DTACK_CPU_n(dt_n), .PLL_LOCK(lock),
        .CLKSEL0(CLKSEL0), .CLKSEL1(CLKSEL1), .BANK_SEL(BANK_SEL), .USE_C7M(USE_C7M),
        .CLK_EN(CLK_EN), .BUSY(BUSY), .LOCK_FAULT(LOCK_FAULT), .APPLIED(APPLIED)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit needs_pll(input logic [3:0] t);
        return (t[3] == 1'b0) && (t[2:0] != 3'b000) && (t[2:0] != 3'b111);
    endfunction

    // Behavioural model. mode: 0 idle, 1 waiting for bus/lock, 2 switching
    // (k = edges since the gate closed).
    logic       m_sw_q [S];
    logic [2:0] m_jp_q [S];
    logic       m_lk_q [S];
    logic [3:0] m_prev, m_stable, m_applied, m_tgt, m_sel0, m_sel1;
    logic       m_bank, m_use, m_fault;
    int         m_run, m_mode, m_k;

    task automatic model_step();
        logic [3:0] r, pend;
        logic lk, fb;
        if (rst) begin
            for (int i = 0; i < S; i++) begin
                m_sw_q[i] = 1'b1; m_jp_q[i] = 3'b000; m_lk_q[i] = 1'b0;
            end
            m_prev = 4'b1000; m_run = 1; m_stable = 4'b1000;
            m_applied = 4'b1000; m_tgt = 4'b1000;
            m_sel0 = 4'b0001; m_sel1 = 4'b0001;
            m_bank = 1'b0; m_use = 1'b1; m_fault = 1'b0;
            m_mode = 0; m_k = 0;
        end else begin
            r  = m_sw_q[S-1] ? 4'b1000 : {1'b0, m_jp_q[S-1]};
            lk = m_lk_q[S-1];
            fb = !lk && needs_pll(m_applied);
            case (m_mode)
                0: if (m_stable != m_applied || fb) m_mode = 1;
                1: begin
                    pend = fb ? 4'b1000 : m_stable;
                    if (pend == m_applied) m_mode = 0;
                    else if (fb) begin
                        m_tgt = 4'b1000; m_fault = 1'b1; m_mode = 2; m_k = 0;
                    end else if (as_n && dt_n && (lk || !needs_pll(pend))) begin
                        m_tgt = pend; m_mode = 2; m_k = 0;
                    end
                end
                default: begin
                    m_k++;
                    if (m_k == G + 1) begin
                        m_use = m_tgt[3];
                        m_bank = m_tgt[2];
                        if (m_tgt[2]) m_sel1 = 4'b0001 << m_tgt[1:0];
                        else          m_sel0 = 4'b0001 << m_tgt[1:0];
                        m_applied = m_tgt;
                    end
                    if (m_k == G + ST + 2) m_mode = 0;
                end
            endcase
            if (r == m_prev) begin
                if (m_run < DEB) m_run++;
            end else begin
                m_run = 1;
            end
            m_prev = r;
            if (m_run >= DEB) m_stable = r;
            for (int i = S - 1; i > 0; i--) begin
                m_sw_q[i] = m_sw_q[i-1]; m_jp_q[i] = m_jp_q[i-1]; m_lk_q[i] = m_lk_q[i-1];
            end
            m_sw_q[0] = sw; m_jp_q[0] = jp; m_lk_q[0] = lock;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("CLKSEL0", 32'(CLKSEL0), 32'(m_sel0));
            chk("CLKSEL1", 32'(CLKSEL1), 32'(m_sel1));
            chk("BANK_SEL", 32'(BANK_SEL), 32'(m_bank));
            chk("USE_C7M", 32'(USE_C7M), 32'(m_use));
            chk("APPLIED", 32'(APPLIED), 32'(m_applied));
            chk("LOCK_FAULT", 32'(LOCK_FAULT), 32'(m_fault));
            chk("CLK_EN", 32'(CLK_EN), 32'(!(m_mode == 2 && m_k <= G + ST)));
            chk("BUSY", 32'(BUSY), 32'(m_mode != 0));
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Ticks until CLK_EN is low; n = ticks taken, or 0 if the bound expired.
    task automatic wait_gate(input int bound, output int n);
        n = 0;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (CLK_EN === 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n, low;
        bit seen_busy, seen_gate;

        // Reset
        rst = 1'b1; sw = 1'b1; jp = 3'b000; as_n = 1'b1; dt_n = 1'b1; lock = 1'b1;
        tick(3);
        chk_on = 1'b1;
        chk("rst_CLKSEL0", 32'(CLKSEL0), 32'h1);
        chk("rst_CLKSEL1", 32'(CLKSEL1), 32'h1);
        chk("rst_USE_C7M", 32'(USE_C7M), 32'h1);
        chk("rst_CLK_EN", 32'(CLK_EN), 32'h1);
        chk("rst_APPLIED", 32'(APPLIED), 32'h8);
        chk("rst_BUSY", 32'(BUSY), 32'h0);
        rst = 1'b0;
        tick(25);

        // Switch to C28M
        sw = 1'b0; jp = 3'b011;
        wait_gate(40, n);
        chk("c28_fall_delay", 32'(n), 32'd20);
        low = (n != 0) ? 1 : 0;
        for (int i = 0; i < 30 && n != 0; i++) begin
            tick();
            if (CLK_EN === 1'b0) low++;
            else break;
        end
        chk("c28_low_cycles", 32'(low), 32'd11);
        tick(2);
        chk("c28_CLKSEL0", 32'(CLKSEL0), 32'h8);
        chk("c28_BANK_SEL", 32'(BANK_SEL), 32'h0);
        chk("c28_USE_C7M", 32'(USE_C7M), 32'h0);
        chk("c28_APPLIED", 32'(APPLIED), 32'h3);
        chk("c28_BUSY", 32'(BUSY), 32'h0);

        // Busy bus holds the switch off
        as_n = 1'b0; jp = 3'b010;
        seen_gate = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (CLK_EN !== 1'b1) seen_gate = 1'b1;
        end
        chk("busbusy_no_gate", 32'(seen_gate), 32'h0);
        chk("busbusy_BUSY", 32'(BUSY), 32'h1);
        as_n = 1'b1;
        wait_gate(5, n);
        chk("busbusy_release_delay", 32'(n), 32'd1);
        tick(14);
        chk("c21_APPLIED", 32'(APPLIED), 32'h2);
        chk("c21_CLKSEL0", 32'(CLKSEL0), 32'h4);

        // Short glitch is filtered
        jp = 3'b011;
        seen_busy = 1'b0; seen_gate = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) jp = 3'b010;
            tick();
            if (BUSY !== 1'b0) seen_busy = 1'b1;
            if (CLK_EN !== 1'b1) seen_gate = 1'b1;
        end
        chk("glitch_no_busy", 32'(seen_busy), 32'h0);
        chk("glitch_no_gate", 32'(seen_gate), 32'h0);

        // Revert during WAIT_BUS returns to idle without gating
        as_n = 1'b0; jp = 3'b011;
        tick(21);
        chk("revert_waiting", 32'(BUSY), 32'h1);
        jp = 3'b010;
        seen_gate = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (CLK_EN !== 1'b1) seen_gate = 1'b1;
        end
        chk("revert_no_gate", 32'(seen_gate), 32'h0);
        chk("revert_idle", 32'(BUSY), 32'h0);
        as_n = 1'b1;
        tick(3);

        // Lock loss fallback from C42M with the bus busy
        jp = 3'b101;
        tick(40);
        chk("c42_APPLIED", 32'(APPLIED), 32'h5);
        chk("c42_CLKSEL1", 32'(CLKSEL1), 32'h2);
        chk("c42_BANK_SEL", 32'(BANK_SEL), 32'h1);
        as_n = 1'b0; lock = 1'b0;
        wait_gate(10, n);
        chk("fallback_delay", 32'(n), 32'd4);
        tick(14);
        chk("fb_USE_C7M", 32'(USE_C7M), 32'h1);
        chk("fb_APPLIED", 32'(APPLIED), 32'h8);
        chk("fb_LOCK_FAULT", 32'(LOCK_FAULT), 32'h1);
        chk("fb_CLKSEL1", 32'(CLKSEL1), 32'h2);
        chk("fb_CLKSEL0", 32'(CLKSEL0), 32'h1);
        lock = 1'b1; as_n = 1'b1;
        tick(40);
        chk("relock_APPLIED", 32'(APPLIED), 32'h5);
        chk("relock_fault_sticky", 32'(LOCK_FAULT), 32'h1);

        // Reset during SETTLE
        jp = 3'b001;
        wait_gate(40, n);
        chk("midrst_gate_seen", 32'(n != 0), 32'h1);
        tick(5);
        rst = 1'b1;
        tick();
        chk("midrst_CLK_EN", 32'(CLK_EN), 32'h1);
        chk("midrst_APPLIED", 32'(APPLIED), 32'h8);
        chk("midrst_BUSY", 32'(BUSY), 32'h0);
        chk("midrst_LOCK_FAULT", 32'(LOCK_FAULT), 32'h0);
        rst = 1'b0;

        // Randomized traffic, checked by the per-cycle model compare
        for (int s = 0; s < 120; s++) begin
            int unsigned hold;
            hold = $urandom_range(1, 45);
            sw   = ($urandom_range(0, 3) == 0);
            jp   = 3'($urandom);
            lock = ($urandom_range(0, 5) != 0);
            rst  = ($urandom_range(0, 40) == 0);
            for (int unsigned h = 0; h < hold; h++) begin
                as_n = ($urandom_range(0, 2) != 0);
                dt_n = ($urandom_range(0, 3) != 0);
                tick();
                rst = 1'b0;
            end
        end
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
